mul_div_unit: RTL and testbench

//   Multi-cycle integer multiply/divide unit for the EX stage, operating beside the ALU.
//   It takes the same forwarded operands (InA, InB) and owns the HI/LO registers.

---
 rtl/mul_div_unit.sv | 211 +++++++++++++++++++++
 tb/tb_mul_div_unit.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// mul_div_unit -- iterative integer multiply/divide unit for the EX stage.
//
// It sits beside the ALU and uses the same forwarded operands. It owns the
// HI/LO registers. The datapath is radix-2: each RUN cycle retires one
// multiplier bit (shift-add) or one quotient bit (restoring shift-subtract).
// Signed operations work on operand magnitudes. The sign is corrected in a
// single FIX cycle, which then commits HI/LO.
//
// Ports
//   clk      rising-edge clock
//   reset_n  asynchronous, active-low reset
//   start    issue op (accepted only while busy==0 and flush==0)
//   op       000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO
//   InA      rs operand (multiplicand / dividend / MTHI-MTLO source)
//   InB      rt operand (multiplier / divisor)
//   flush    abort the in-flight op; HI/LO keep their old values
//   busy     high while an op occupies RUN or FIX
//   done     one-cycle pulse when HI/LO commit a MULT/DIV result
//   hi, lo   HI/LO registers (product upper/lower, remainder/quotient)
//
// Configuration
//   MDU_EARLY_TERM_EN  when defined, a multiply leaves RUN as soon as the
//                      remaining multiplier bits are all zero. The partial
//                      product is then aligned in FIX. Divide timing does
//                      not change.
module mul_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] InA,
  input  logic [WIDTH-1:0] InB,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [2:0]       OP_MTHI  = 3'b100;
  localparam logic [2:0]       OP_MTLO  = 3'b101;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t           state;
  logic [WIDTH-1:0] acc;     // upper product half / partial remainder
  logic [WIDTH-1:0] q;       // multiplier shifting out, product/quotient shifting in
  logic [WIDTH-1:0] mcand;   // multiplicand or divisor magnitude
  logic [CNT_W-1:0] cnt;
  logic             is_div;
  logic             neg_q;   // negate product (multiply) or quotient (divide)
  logic             neg_r;   // negate remainder (divide only)

  // Two's-complement conditional negation of a single-width value.
  function automatic logic [WIDTH-1:0] cond_neg_w(input logic [WIDTH-1:0] v,
                                                  input logic en);
    return en ? ('0 - v) : v;
  endfunction

  // Two's-complement conditional negation of a double-width product.
  function automatic logic [2*WIDTH-1:0] cond_neg_dw(input logic [2*WIDTH-1:0] v,
                                                     input logic en);
    return en ? ('0 - v) : v;
  endfunction

  // Operand decode at issue
  logic             op_sgnd, sgn_a, sgn_b;
  logic [WIDTH-1:0] mag_a, mag_b;

  always_comb begin
    op_sgnd = ~op[0];
    sgn_a   = op_sgnd & InA[WIDTH-1];
    sgn_b   = op_sgnd & InB[WIDTH-1];
    mag_a   = cond_neg_w(InA, sgn_a);
    mag_b   = cond_neg_w(InB, sgn_b);
  end

  // One iteration step
  logic [WIDTH:0]   add_sum, shl_rem, sub_diff;
  logic [WIDTH-1:0] step_acc, step_q;
  logic [CNT_W-1:0] cnt_nxt;
  logic             run_last;

  always_comb begin
    add_sum  = {1'b0, acc} + (q[0] ? {1'b0, mcand} : '0);
    shl_rem  = {acc, q[WIDTH-1]};
    sub_diff = shl_rem - {1'b0, mcand};
    cnt_nxt  = cnt - CNT_ONE;
    if (is_div) begin
      // Restoring division: the borrow bit decides whether the subtraction is kept.
      if (!sub_diff[WIDTH]) begin
        step_acc = sub_diff[WIDTH-1:0];
        step_q   = {q[WIDTH-2:0], 1'b1};
      end else begin
        step_acc = shl_rem[WIDTH-1:0];
        step_q   = {q[WIDTH-2:0], 1'b0};
      end
    end else begin
      // Shift-add multiply: the carry of the add becomes the new top product bit.
      step_acc = add_sum[WIDTH:1];
      step_q   = {add_sum[0], q[WIDTH-1:1]};
    end
`ifdef MDU_EARLY_TERM_EN
    // The multiplier bits not yet consumed are the low cnt_nxt bits of q>>1.
    run_last = (cnt_nxt == '0) ||
               (!is_div && (((q >> 1) & ~({WIDTH{1'b1}} << cnt_nxt)) == '0));
`else
    run_last = (cnt_nxt == '0);
`endif
  end

  // Final sign correction and alignment
  logic [2*WIDTH-1:0] mul_raw, mul_fix;
  logic [WIDTH-1:0]   fix_hi, fix_lo;

  always_comb begin
`ifdef MDU_EARLY_TERM_EN
    // Any skipped iterations would only have shifted the product right.
    mul_raw = {acc, q} >> cnt;
`else
    mul_raw = {acc, q};
`endif
    mul_fix = cond_neg_dw(mul_raw, neg_q);
    if (is_div) begin
      fix_lo = cond_neg_w(q, neg_q);
      fix_hi = cond_neg_w(acc, neg_r);
    end else begin
      fix_hi = mul_fix[2*WIDTH-1:WIDTH];
      fix_lo = mul_fix[WIDTH-1:0];
    end
  end

  // Control FSM and HI/LO
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= S_IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      acc    <= '0;
      q      <= '0;
      mcand  <= '0;
      cnt    <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && !flush) begin
            if (!op[2]) begin
              is_div <= op[1];
              acc    <= '0;
              cnt    <= CNT_INIT;
              state  <= S_RUN;
              busy   <= 1'b1;
              if (op[1]) begin
                q     <= mag_a;
                mcand <= mag_b;
                // A zero divisor leaves the quotient as all ones, regardless of signs.
                neg_q <= (sgn_a ^ sgn_b) & (InB != '0);
                neg_r <= sgn_a;
              end else begin
                q     <= mag_b;
                mcand <= mag_a;
                neg_q <= sgn_a ^ sgn_b;
                neg_r <= 1'b0;
              end
            end else if (op == OP_MTHI) begin
              hi <= InA;
            end else if (op == OP_MTLO) begin
              lo <= InA;
            end
          end
        end
        S_RUN: begin
          if (flush) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            acc <= step_acc;
            q   <= step_q;
            cnt <= cnt_nxt;
            if (run_last) state <= S_FIX;
          end
        end
        S_FIX: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          if (!flush) begin
            hi   <= fix_hi;
            lo   <= fix_lo;
            done <= 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
module tb_mul_div_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic         flush = 1'b0;
  logic [2:0]   op = 3'b000;
  logic [W-1:0] InA = '0;
  logic [W-1:0] InB = '0;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mul_div_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op), .InA(InA), .InB(InB),
    .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  typedef struct {
    string      name;
    logic [2:0] op;
    logic [31:0] a, b, eh, el;
  } vec_t;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: plain arithmetic on 64-bit values.
  function automatic void model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] h, output logic [31:0] l);
    logic signed [63:0] sa, sb, sq, sr;
    logic [63:0] p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    h = '0;
    l = '0;
    case (o)
      3'd0: begin p = sa * sb; h = p[63:32]; l = p[31:0]; end
      3'd1: begin p = {32'b0, a} * {32'b0, b}; h = p[63:32]; l = p[31:0]; end
      3'd2: begin
        if (b == 0) begin l = '1; h = a; end
        else begin sq = sa / sb; sr = sa % sb; l = sq[31:0]; h = sr[31:0]; end
      end
      3'd3: begin
        if (b == 0) begin l = '1; h = a; end
        else begin l = a / b; h = a % b; end
      end
      default: ;
    endcase
  endfunction

  // Issue a MULT/DIV op and wait (bounded) for done.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output bit busy_ok);
    @(negedge clk);
    start = 1'b1; op = o; InA = a; InB = b;
    @(posedge clk); #1;
    start = 1'b0;
    InA = $urandom; InB = $urandom;
    lat = 0;
    busy_ok = 1'b1;
    while (1) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
      if (done === 1'b1 || lat >= 100) break;
    end
  endtask

  task automatic do_and_check(input string nm, input logic [2:0] o, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
    int lat;
    bit bok;
    bit full_lat;
    run_op(o, a, b, lat, bok);
    check({nm, " done"}, 64'(done), 64'(1));
    check({nm, " hi"}, 64'(hi), 64'(eh));
    check({nm, " lo"}, 64'(lo), 64'(el));
    check({nm, " busy_cleared"}, 64'(busy), 64'(0));
    check({nm, " busy_held"}, 64'(bok), 64'(1));
`ifdef MDU_EARLY_TERM_EN
    full_lat = o[1];
`else
    full_lat = 1'b1;
`endif
    if (full_lat) check({nm, " latency"}, 64'(lat), 64'(33));
    else          check({nm, " latency_le"}, 64'(lat <= 33), 64'(1));
    @(posedge clk); #1;
    check({nm, " done_one_cycle"}, 64'(done), 64'(0));
  endtask

  task automatic move_to(input logic [2:0] o, input logic [31:0] v);
    @(negedge clk);
    start = 1'b1; op = o; InA = v;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] v;
    case ($urandom_range(0, 6))
      0: v = 32'h0;
      1: v = $urandom_range(1, 20);
      2: v = 32'h80000000;
      3: v = 32'hFFFFFFFF;
      4: v = 32'h0 - $urandom_range(1, 20);
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    vec_t tbl[10];
    logic [31:0] eh, el;
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    bit seen_done;
    int lat;
    bit bok;

    tbl[0] = '{"mult_7_m3",      3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB};
    tbl[1] = '{"multu_max",      3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    tbl[2] = '{"div_m7_2",       3'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    tbl[3] = '{"div_overflow",   3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    tbl[4] = '{"divu_5_0",       3'd3, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF};
    tbl[5] = '{"div_m7_0",       3'd2, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF};
    tbl[6] = '{"mult_min_min",   3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    tbl[7] = '{"divu_max_1",     3'd3, 32'hFFFFFFFF, 32'd1,        32'h00000000, 32'hFFFFFFFF};
    tbl[8] = '{"div_7_m2",       3'd2, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    tbl[9] = '{"multu_0_x",      3'd1, 32'd0,        32'd12345,    32'h00000000, 32'h00000000};

    // Reset state
    #1;
    check("reset busy", 64'(busy), 64'(0));
    check("reset done", 64'(done), 64'(0));
    check("reset hi", 64'(hi), 64'(0));
    check("reset lo", 64'(lo), 64'(0));
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Directed vectors
    for (int i = 0; i < 10; i++)
      do_and_check(tbl[i].name, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].eh, tbl[i].el);

    // MTHI / MTLO and unused op codes
    move_to(3'b100, 32'h000000AA);
    check("mthi hi", 64'(hi), 64'(32'hAA));
    check("mthi busy", 64'(busy), 64'(0));
    check("mthi done", 64'(done), 64'(0));
    move_to(3'b101, 32'h00000055);
    check("mtlo lo", 64'(lo), 64'(32'h55));
    check("mtlo hi_kept", 64'(hi), 64'(32'hAA));
    move_to(3'b110, 32'h12345678);
    check("noop hi", 64'(hi), 64'(32'hAA));
    check("noop lo", 64'(lo), 64'(32'h55));
    check("noop busy", 64'(busy), 64'(0));

    // Flush mid-divide; an MTHI issued while busy must be ignored
    @(negedge clk);
    start = 1'b1; op = 3'b011; InA = 32'd100; InB = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c < 10; c++) begin
      @(negedge clk);
      start = (c == 5);
      op = 3'b100;
      InA = 32'h00001234;
    end
    @(negedge clk);
    start = 1'b0; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush busy", 64'(busy), 64'(0));
    check("flush hi", 64'(hi), 64'(32'hAA));
    check("flush lo", 64'(lo), 64'(32'h55));
    seen_done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen_done = 1'b1;
    end
    check("flush no_done", 64'(seen_done), 64'(0));
    check("flush hi_after", 64'(hi), 64'(32'hAA));

    // Flush and start together in IDLE: the op is dropped
    @(negedge clk);
    flush = 1'b1; start = 1'b1; op = 3'b100; InA = 32'h77;
    @(posedge clk); #1;
    check("idle flush mthi", 64'(hi), 64'(32'hAA));
    @(negedge clk);
    op = 3'b011; InA = 32'd9; InB = 32'd2;
    @(posedge clk); #1;
    flush = 1'b0; start = 1'b0;
    check("idle flush divu busy", 64'(busy), 64'(0));

    // Asynchronous reset in the middle of RUN
    @(negedge clk);
    start = 1'b1; op = 3'b000; InA = 32'd1234; InB = 32'd5678;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    check("pre_reset busy", 64'(busy), 64'(1));
    reset_n = 1'b0;
    #1;
    check("async reset busy", 64'(busy), 64'(0));
    check("async reset done", 64'(done), 64'(0));
    check("async reset hi", 64'(hi), 64'(0));
    check("async reset lo", 64'(lo), 64'(0));
    @(negedge clk);
    reset_n = 1'b1;
    do_and_check("after_reset multu", 3'd1, 32'd3, 32'd5, 32'd0, 32'd15);

`ifdef MDU_EARLY_TERM_EN
    run_op(3'd1, 32'd3, 32'd5, lat, bok);
    check("early lo", 64'(lo), 64'(15));
    check("early latency", 64'(lat <= 5), 64'(1));
`endif

    // Randomized operations against the reference model
    for (int i = 0; i < 48; i++) begin
      ro = 3'($urandom_range(0, 3));
      ra = pick();
      rb = pick();
      model(ro, ra, rb, eh, el);
      do_and_check($sformatf("rand%0d op%0d %h %h", i, ro, ra, rb), ro, ra, rb, eh, el);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
